// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM with a shared
// tri-state data bus. Each accepted transaction occupies the SRAM for exactly one cycle.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rw,
    inout  wire  [DATA_W-1:0] sram_data
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              drive_q, drive_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic grant0, grant1, sel_rw;

    // On a tie, the requester that did not win last time gets the grant.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == StIdle) && !reset && grant0;
    assign req1_ready = (state_q == StIdle) && !reset && grant1;
    assign sel_rw     = req1_ready ? req1_rw : req0_rw;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = 1'b0;
        drive_d      = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    id_d         = req1_ready;
                    last_grant_d = req1_ready;
                    addr_d       = req1_ready ? req1_addr : req0_addr;
                    wdata_d      = req1_ready ? req1_wdata : req0_wdata;
                    rw_d         = sel_rw;
                    drive_d      = sel_rw;
                    state_d      = sel_rw ? StWrite : StRead;
                end
            end
            StWrite: state_d = StIdle;
            StRead: begin
                state_d = StIdle;
                if (id_q) begin
                    rdata1_d  = sram_data;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = sram_data;
                    rvalid0_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            drive_q      <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            drive_q      <= drive_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign sram_addr   = addr_q;
    assign sram_rw     = rw_q;
    assign sram_data   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a per-cycle vector table drives both requesters against an SRAM
// model; read results are predicted into a scoreboard queue and matched against rvalid pulses.
module tb_sram_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_rw = 1'b0, req0_ready, req0_rvalid;
    logic [7:0] req0_addr = '0, req0_wdata = '0, req0_rdata;
    logic       req1_valid = 1'b0, req1_rw = 1'b0, req1_ready, req1_rvalid;
    logic [7:0] req1_addr = '0, req1_wdata = '0, req1_rdata;
    logic [7:0] sram_addr;
    logic       sram_rw;
    wire  [7:0] sram_data;

    sram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rw    (req0_rw),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_rvalid(req0_rvalid),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rw    (req1_rw),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_rvalid(req1_rvalid),
        .req1_rdata (req1_rdata),
        .sram_addr  (sram_addr),
        .sram_rw    (sram_rw),
        .sram_data  (sram_data)
    );

    always #5 clock = ~clock;

    // SRAM model: drives the bus whenever sram_rw=0, writes on the edge when sram_rw=1.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    assign sram_data = sram_rw ? 8'hzz : mem[sram_addr];
    always @(posedge clock) if (sram_rw) mem[sram_addr] <= sram_data;

    typedef struct {
        bit       rst;
        bit       v0;
        bit       rw0;
        bit [7:0] a0;
        bit [7:0] d0;
        bit       v1;
        bit       rw1;
        bit [7:0] a1;
        bit [7:0] d1;
        bit [1:0] rdy;
    } vec_t;

    typedef struct {
        bit       id;
        bit [7:0] data;
        int       cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference state
    bit [7:0] ref_mem [256];
    bit [7:0] last_rd [2];
    int       cyc = 0;
    bit       pv = 0;
    int       page = 0;
    bit       prw = 0;
    bit [7:0] pa = '0, pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic vec_t mk(bit rst, bit v0, bit rw0, bit [7:0] a0, bit [7:0] d0,
                                bit v1, bit rw1, bit [7:0] a1, bit [7:0] d1, bit [1:0] rdy);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.rw0 = rw0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.rw1 = rw1; v.a1 = a1; v.d1 = d1; v.rdy = rdy;
        return v;
    endfunction

    // Checks outputs produced by the previous clock edge.
    task automatic observe();
        logic [1:0] exp_rv;
        exp_t e;
        cyc++;
        if (pv && page == 0) begin
            chk("sram_rw_busy", {31'd0, sram_rw}, {31'd0, prw});
            chk("sram_addr", {24'd0, sram_addr}, {24'd0, pa});
            if (prw) chk("bus_wdata", {24'd0, sram_data}, {24'd0, pd});
            else     chk("bus_sram_rd", {24'd0, sram_data}, {24'd0, ref_mem[pa]});
            page = 1;
        end else begin
            if (pv) begin
                if (prw) ref_mem[pa] = pd;
                pv = 0;
            end
            chk("sram_rw_idle", {31'd0, sram_rw}, 32'd0);
            chk("bus_idle", {24'd0, sram_data}, {24'd0, ref_mem[sram_addr]});
        end
        exp_rv = 2'b00;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            exp_rv = e.id ? 2'b10 : 2'b01;
            last_rd[e.id] = e.data;
        end
        chk("rvalid", {30'd0, req1_rvalid, req0_rvalid}, {30'd0, exp_rv});
        chk("rdata0", {24'd0, req0_rdata}, {24'd0, last_rd[0]});
        chk("rdata1", {24'd0, req1_rdata}, {24'd0, last_rd[1]});
    endtask

    task automatic apply(input vec_t v);
        bit id;
        @(negedge clock);
        observe();
        req0_valid = v.v0; req0_rw = v.rw0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_rw = v.rw1; req1_addr = v.a1; req1_wdata = v.d1;
        if (v.rst) begin
            reset = 1'b1;
            #1;
            chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("rst_sram_rw", {31'd0, sram_rw}, 32'd0);
            chk("rst_sram_addr", {24'd0, sram_addr}, 32'd0);
            chk("rst_bus", {24'd0, sram_data}, {24'd0, ref_mem[0]});
            chk("rst_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
            chk("rst_rdata", {16'd0, req1_rdata, req0_rdata}, 32'd0);
            sb.delete();
            pv = 0;
            last_rd[0] = '0;
            last_rd[1] = '0;
            #2 reset = 1'b0;
        end
        #1;
        chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, v.rdy});
        if (v.rdy != 2'b00) begin
            id   = v.rdy[1];
            pv   = 1;
            page = 0;
            prw  = id ? v.rw1 : v.rw0;
            pa   = id ? v.a1 : v.a0;
            pd   = id ? v.d1 : v.d0;
            if (!prw) sb.push_back('{id: id, data: ref_mem[pa], cyc: cyc + 2});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Single requester write then read-back
        tbl.push_back(mk(1, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        // Both requesters held valid: grants alternate starting with req0
        tbl.push_back(mk(1, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b01));
        tbl.push_back(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b00));
        tbl.push_back(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b10));
        tbl.push_back(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b00));
        tbl.push_back(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b01));
        tbl.push_back(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 2'b10));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        // req1 alone, back-to-back reads; req0 pulses valid while busy, then drops it
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 2'b10));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 2'b10));
        tbl.push_back(mk(0, 1, 0, 8'h55, 8'h00, 1, 0, 8'h10, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h55, 8'h00, 1, 0, 8'h10, 8'h00, 2'b10));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        // Reset during a write aborts it; reset during a read suppresses rvalid
        tbl.push_back(mk(0, 1, 1, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 2'b10));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 2'b10));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00));

        repeat (2) @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
